// File: rtl/ysyx_22050710_seq.sv
// Multi-cycle sequencer for the NPC core: fetch/data handshakes, single commit per instruction,
// halt on ebreak, error on bus timeout. Define YSYX_22050710_PERF_EN to build the perf counters.
module ysyx_22050710_seq #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  input  logic        i_if_rvalid,
  output logic        o_inst_we,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic        i_is_ebreak,
  input  logic        i_RegWr,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  output logic        o_reg_wen,
  output logic        o_pc_we,
  output logic        o_halt,
  output logic        o_err,
  output logic [63:0] o_cycle_cnt,
  output logic [63:0] o_instret,
  output logic [2:0]  o_state
);

  // Handshake: a request (valid) is raised on state entry and held unchanged until the
  // cycle ready is seen; the transfer completes on that edge. Responses (rvalid) are
  // only consumed in the matching wait state and ignored everywhere else.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FWAIT = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_MWAIT = 3'd5,
    S_HALT  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT[TIMEOUT_W-1:0];

  state_t               state;
  state_t               next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 stall;
  logic                 timed_out;

  assign timed_out = (wait_cnt == TO_VAL);

  // Exit conditions are tested before the timeout so a late response still wins.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    o_inst_we  = 1'b0;
    o_reg_wen  = 1'b0;
    o_pc_we    = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        if (i_if_ready)     next_state = S_FWAIT;
        else if (timed_out) next_state = S_ERR;
        else                stall = 1'b1;
      end
      S_FWAIT: begin
        if (i_if_rvalid) begin
          o_inst_we  = 1'b1;
          next_state = S_EXEC;
        end else if (timed_out) next_state = S_ERR;
        else                    stall = 1'b1;
      end
      S_EXEC: begin
        if (i_is_ebreak)                  next_state = S_HALT;
        else if (i_is_load || i_is_store) next_state = S_MEM;
        else begin
          o_reg_wen  = i_RegWr;
          o_pc_we    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_MEM: begin
        if (i_mem_ready) begin
          if (i_is_load) next_state = S_MWAIT;
          else begin
            o_pc_we    = 1'b1;
            next_state = S_FETCH;
          end
        end else if (timed_out) next_state = S_ERR;
        else                    stall = 1'b1;
      end
      S_MWAIT: begin
        if (i_mem_rvalid) begin
          o_reg_wen  = i_RegWr;
          o_pc_we    = 1'b1;
          next_state = S_FETCH;
        end else if (timed_out) next_state = S_ERR;
        else                    stall = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) wait_cnt <= '0;
      else if (stall)          wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign o_if_valid  = (state == S_FETCH);
  assign o_mem_valid = (state == S_MEM);
  assign o_halt      = (state == S_HALT);
  assign o_err       = (state == S_ERR);
  assign o_state     = state;

`ifdef YSYX_22050710_PERF_EN
  logic active;
  logic [63:0] cycle_cnt;
  logic [63:0] instret;

  assign active = (state == S_FETCH) || (state == S_FWAIT) || (state == S_EXEC) ||
                  (state == S_MEM)   || (state == S_MWAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (active)  cycle_cnt <= cycle_cnt + 64'd1;
      if (o_pc_we) instret   <= instret + 64'd1;
    end
  end

  assign o_cycle_cnt = cycle_cnt;
  assign o_instret   = instret;
`else
  assign o_cycle_cnt = '0;
  assign o_instret   = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050710_seq.sv
// Directed bench for ysyx_22050710_seq: ALU/load/store/ebreak flows, timeout, reset mid-load.
module tb_ysyx_22050710_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_if_valid;
  logic        i_if_ready;
  logic        i_if_rvalid;
  logic        o_inst_we;
  logic        i_is_load;
  logic        i_is_store;
  logic        i_is_ebreak;
  logic        i_RegWr;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic        o_reg_wen;
  logic        o_pc_we;
  logic        o_halt;
  logic        o_err;
  logic [63:0] o_cycle_cnt;
  logic [63:0] o_instret;
  logic [2:0]  o_state;

  int n_vec  = 0;
  int n_miss = 0;

  ysyx_22050710_seq #(.TIMEOUT_W(8), .TIMEOUT(200)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_if_valid(o_if_valid), .i_if_ready(i_if_ready), .i_if_rvalid(i_if_rvalid),
    .o_inst_we(o_inst_we),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_is_ebreak(i_is_ebreak),
    .i_RegWr(i_RegWr),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid),
    .o_reg_wen(o_reg_wen), .o_pc_we(o_pc_we), .o_halt(o_halt), .o_err(o_err),
    .o_cycle_cnt(o_cycle_cnt), .o_instret(o_instret), .o_state(o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_valid"},  {63'd0, o_if_valid},  64'd0);
    chk({tag, "_mem_valid"}, {63'd0, o_mem_valid}, 64'd0);
    chk({tag, "_inst_we"},   {63'd0, o_inst_we},   64'd0);
    chk({tag, "_reg_wen"},   {63'd0, o_reg_wen},   64'd0);
    chk({tag, "_pc_we"},     {63'd0, o_pc_we},     64'd0);
    chk({tag, "_halt"},      {63'd0, o_halt},      64'd0);
    chk({tag, "_err"},       {63'd0, o_err},       64'd0);
    chk({tag, "_cycle_cnt"}, o_cycle_cnt,          64'd0);
    chk({tag, "_instret"},   o_instret,            64'd0);
  endtask

  // driver tasks
  task automatic clear_inputs();
    i_if_ready   = 1'b0;
    i_if_rvalid  = 1'b0;
    i_is_load    = 1'b0;
    i_is_store   = 1'b0;
    i_is_ebreak  = 1'b0;
    i_RegWr      = 1'b0;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
  endtask

  // Leaves the bench mid-cycle with reset released and the DUT in IDLE.
  task automatic do_reset(input string tag);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk_quiet(tag);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Advance to 1ns after the next rising edge: one new cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [63:0] exp_instret;
  logic [63:0] exp_cycles;
  int cnt_a;
  int cnt_b;

  initial begin
    i_rst_n = 1'b1;
    clear_inputs();

    // ALU stream: commit every 3rd cycle from FETCH entry
    i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_RegWr = 1'b1;
    do_reset("rst0");
    chk("idle_if_valid", {63'd0, o_if_valid}, 64'd0);
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("alu_if_valid", {63'd0, o_if_valid}, {63'd0, (c % 3) == 0});
      chk("alu_inst_we",  {63'd0, o_inst_we},  {63'd0, (c % 3) == 1});
      chk("alu_pc_we",    {63'd0, o_pc_we},    {63'd0, (c % 3) == 2});
      chk("alu_reg_wen",  {63'd0, o_reg_wen},  {63'd0, (c % 3) == 2});
    end
    tick();
`ifdef YSYX_22050710_PERF_EN
    exp_instret = 64'd10; exp_cycles = 64'd30;
`else
    exp_instret = 64'd0;  exp_cycles = 64'd0;
`endif
    chk("alu_instret",   o_instret,   exp_instret);
    chk("alu_cycle_cnt", o_cycle_cnt, exp_cycles);

    // Load: ready 4 cycles late, rvalid 2 cycles after ready
    clear_inputs();
    i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_is_load = 1'b1; i_RegWr = 1'b1;
    do_reset("rst1");
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c <= 10; c++) begin
      tick();
      i_mem_ready  = (c == 7);
      i_mem_rvalid = (c == 9);
      #1;
      if (o_mem_valid) cnt_a++;
      if (o_reg_wen)   cnt_b++;
      if (c == 2) chk("ld_exec_reg_wen", {63'd0, o_reg_wen}, 64'd0);
      if (c == 3) chk("ld_mem_valid_first", {63'd0, o_mem_valid}, 64'd1);
      if (c == 8) chk("ld_mwait_pc_we", {63'd0, o_pc_we}, 64'd0);
      if (c == 9) begin
        chk("ld_reg_wen", {63'd0, o_reg_wen}, 64'd1);
        chk("ld_pc_we",   {63'd0, o_pc_we},   64'd1);
      end
      if (c == 10) chk("ld_refetch", {63'd0, o_if_valid}, 64'd1);
    end
    chk("ld_mem_valid_cycles", 64'(cnt_a), 64'd5);
    chk("ld_reg_wen_pulses",   64'(cnt_b), 64'd1);

    // Store with RegWr=0: commit on the ready cycle, no MWAIT
    clear_inputs();
    i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_is_store = 1'b1; i_mem_rvalid = 1'b1;
    do_reset("rst2");
    cnt_b = 0;
    for (int c = 0; c <= 6; c++) begin
      tick();
      i_mem_ready = (c == 5);
      #1;
      if (o_reg_wen) cnt_b++;
      if (c == 4) chk("st_wait_pc_we", {63'd0, o_pc_we}, 64'd0);
      if (c == 5) chk("st_pc_we", {63'd0, o_pc_we}, 64'd1);
      if (c == 6) begin
        chk("st_refetch",   {63'd0, o_if_valid},  64'd1);
        chk("st_mem_valid", {63'd0, o_mem_valid}, 64'd0);
        chk("st_no_commit", {63'd0, o_pc_we},     64'd0);
      end
    end
    chk("st_reg_wen_pulses", 64'(cnt_b), 64'd0);

    // ebreak (with load also set): HALT, no commit, no further fetch
    clear_inputs();
    i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_is_ebreak = 1'b1; i_is_load = 1'b1;
    i_RegWr = 1'b1; i_mem_ready = 1'b1;
    do_reset("rst3");
    for (int c = 0; c <= 3; c++) tick();
    chk("eb_halt",      {63'd0, o_halt},      64'd1);
    chk("eb_mem_valid", {63'd0, o_mem_valid}, 64'd0);
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (o_if_valid || o_pc_we || o_reg_wen) cnt_a++;
      if (!o_halt) cnt_b++;
    end
    chk("eb_no_activity", 64'(cnt_a), 64'd0);
    chk("eb_halt_sticky", 64'(cnt_b), 64'd0);
`ifdef YSYX_22050710_PERF_EN
    exp_cycles = 64'd3;
`else
    exp_cycles = 64'd0;
`endif
    chk("eb_cycle_cnt", o_cycle_cnt, exp_cycles);
    chk("eb_instret",   o_instret,   64'd0);

    // Timeout: if_ready held low
    clear_inputs();
    do_reset("rst4");
    for (int c = 0; c <= 200; c++) tick();
    chk("to_not_yet_err", {63'd0, o_err},      64'd0);
    chk("to_still_fetch", {63'd0, o_if_valid}, 64'd1);
    tick();
    chk("to_err",          {63'd0, o_err},      64'd1);
    chk("to_if_valid_off", {63'd0, o_if_valid}, 64'd0);
    i_if_ready = 1'b1; i_if_rvalid = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!o_err || o_if_valid) cnt_a++;
    end
    chk("to_err_sticky", 64'(cnt_a), 64'd0);

    // Ready arriving on the timeout cycle wins
    clear_inputs();
    do_reset("rst5");
    for (int c = 0; c <= 200; c++) tick();
    i_if_ready = 1'b1; i_if_rvalid = 1'b1;
    #1;
    chk("to2_if_valid", {63'd0, o_if_valid}, 64'd1);
    tick();
    chk("to2_no_err",  {63'd0, o_err},     64'd0);
    chk("to2_inst_we", {63'd0, o_inst_we}, 64'd1);
    tick();
    chk("to2_commit",  {63'd0, o_pc_we},   64'd1);

    // Reset while in MWAIT, then a late rvalid
    clear_inputs();
    i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_is_load = 1'b1; i_RegWr = 1'b1;
    i_mem_ready = 1'b1;
    do_reset("rst6");
    for (int c = 0; c <= 4; c++) tick();
    chk("mr_mwait_reg_wen",   {63'd0, o_reg_wen},   64'd0);
    chk("mr_mwait_mem_valid", {63'd0, o_mem_valid}, 64'd0);
    i_rst_n = 1'b0;
    #1;
    chk_quiet("mr_rst");
    i_mem_rvalid = 1'b1;
    #1;
    chk("mr_late_rvalid", {63'd0, o_reg_wen}, 64'd0);
    tick();
    chk_quiet("mr_rst_held");
    @(negedge i_clk);
    i_if_ready = 1'b0;
    i_rst_n = 1'b1;
    #1;
    chk("mr_idle_if_valid", {63'd0, o_if_valid}, 64'd0);
    chk("mr_idle_reg_wen",  {63'd0, o_reg_wen},  64'd0);
    tick();
    chk("mr_fetch_if_valid", {63'd0, o_if_valid}, 64'd1);
    chk("mr_fetch_reg_wen",  {63'd0, o_reg_wen},  64'd0);
    chk("mr_fetch_pc_we",    {63'd0, o_pc_we},    64'd0);
    tick();
    chk("mr_fetch2_if_valid", {63'd0, o_if_valid}, 64'd1);
    chk("mr_fetch2_reg_wen",  {63'd0, o_reg_wen},  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
